seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits, minimum 2.
REQ-002 Parameter LEN_W, default 4: width of pat_len and fill; SHALL satisfy 2**LEN_W > PAT_W.
REQ-003 Parameter CNT_W, default 8: match counter width.
REQ-004 Parameter DEF_PAT, default 8'b0000_0101: pattern loaded at reset.
REQ-005 Parameter DEF_LEN, default 3: pattern length loaded at reset.
REQ-006 Parameter DEF_OVL, default 1: overlap mode loaded at reset.
REQ-007 clock  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 din  input  1  serial data bit.
REQ-010 din_valid  input  1  din is sampled only when this input is 1.
REQ-011 cfg_load  input  1  one-cycle pulse; captures pat, pat_len and overlap.
REQ-012 pat  input  PAT_W  pattern; pat[len-1] is the first bit received and pat[0] the last.
REQ-013 pat_len  input  LEN_W  pattern length.
REQ-014 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-015 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-016 dout  output  1  registered one-cycle match pulse.
REQ-017 match_cnt  output  CNT_W  saturating count of matches.
REQ-018 fill  output  LEN_W  number of valid history bits, saturating at the active length (observable state).

Function
REQ-019 The block SHALL hold active configuration registers pat_r, len_r and ovl_r, plus a PAT_W-bit history register hist.
REQ-020 On a rising edge with din_valid=1 and cfg_load=0:
- hist SHALL be updated to {hist[PAT_W-2:0], din}.
- fill SHALL be updated to min(fill+1, len_r).
REQ-021 A match SHALL occur on that edge when all of the following hold:
- len_r != 0;
- the updated fill == len_r;
- the updated hist[len_r-1:0] == pat_r[len_r-1:0].
REQ-022 dout SHALL be 1 for exactly the one clock cycle following the matching edge and 0 at all other times.
REQ-023 When din_valid=0, hist and fill SHALL hold their values, and dout SHALL be 0 in the following cycle.
REQ-024 In overlap mode (ovl_r=1), a match SHALL NOT alter fill, so matches can occur on consecutive valid bits where the pattern allows.
REQ-025 In non-overlap mode (ovl_r=0), a match SHALL set fill to 0, so the next match needs len_r fresh valid bits.
REQ-026 On cfg_load=1:
- pat_r, ovl_r and len_r SHALL be captured, with len_r = min(pat_len, PAT_W);
- hist, fill and dout SHALL be cleared;
- din on that edge SHALL be discarded even if din_valid=1;
- match_cnt SHALL be unaffected.
REQ-027 len_r=0 SHALL disable detection: no matches occur, and fill stays 0.
REQ-028 match_cnt SHALL increment by 1 on each match and SHALL saturate at 2**CNT_W-1 without wrapping.
REQ-029 cnt_clr=1 SHALL set match_cnt to 0; when cnt_clr and a match occur on the same edge, match_cnt SHALL become 0 and dout SHALL still pulse.
REQ-030 cfg_load and cnt_clr on the same edge SHALL both take effect.

Reset
REQ-031 While reset=1, the following SHALL hold asynchronously, regardless of clock:
- pat_r = DEF_PAT, len_r = DEF_LEN, ovl_r = DEF_OVL;
- hist = 0, fill = 0, dout = 0, match_cnt = 0.
REQ-032 Reset asserted mid-sequence SHALL discard all partial history; the first rising edge after deassertion SHALL be treated as the first valid bit.
REQ-033 With default parameters and din_valid tied to 1, the block SHALL behave as an overlapping "101" detector.

Verification
REQ-034 Default config, din_valid=1, din=0,1,0,1,0,1,1 SHALL produce:
- dout pulses after the 4th and 6th bits;
- match_cnt=2.
REQ-035 Load pat=101, pat_len=3, overlap=0, then drive din=1,0,1,0,1 SHALL produce:
- one dout pulse, after the 3rd bit;
- match_cnt=1;
- fill=2 at end.
REQ-036 Load pat=8'hA5, pat_len=8, then drive din=1,0,1,0,0,1,0,1 with din_valid low for 2 cycles between bits 4 and 5 SHALL produce:
- one pulse, after the 8th bit;
- no dout during the gap.
REQ-037 Default config, din=1,0, then reset pulse, then din=1 SHALL produce no pulse, with fill=1 after the final bit.
REQ-038 CNT_W=2, pat=11, pat_len=2, overlap=1, eight 1s SHALL produce:
- seven pulses;
- match_cnt saturating at 3;
- cnt_clr coincident with the 8th match gives match_cnt=0.
REQ-039 cfg_load asserted on the same edge as a completing bit SHALL produce:
- no pulse;
- hist=0 and fill=0;
- match_cnt unchanged.

Source files
------------

// File: rtl/seq_det_param.sv
// Serial pattern detector with a run-time loadable pattern, length and overlap mode.
// dout is a registered one-cycle match pulse; match_cnt is a saturating match counter.
module seq_det_param #(
  parameter int                 PAT_W   = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_W-1:0]   DEF_PAT = PAT_W'(5),
  parameter logic [LEN_W-1:0]   DEF_LEN = LEN_W'(3),
  parameter logic               DEF_OVL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] fill
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_r, pat_next;
  logic [LEN_W-1:0] len_r, len_next;
  logic             ovl_r, ovl_next;
  logic [PAT_W-1:0] hist, hist_next;
  logic [LEN_W-1:0] fill_next;
  logic             dout_next;
  logic [CNT_W-1:0] cnt_next;

  logic [PAT_W-1:0] len_mask;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic             hit;

  // Only the low len_r bits of history take part in the comparison.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
      assign len_mask[gi] = (len_r > IDX);
    end
  endgenerate

  assign hist_shift = {hist[PAT_W-2:0], din};
  assign fill_inc   = (fill >= len_r) ? len_r : fill + LEN_W'(1);
  assign hit        = din_valid && !cfg_load && (len_r != '0) && (fill_inc == len_r) &&
                      (((hist_shift ^ pat_r) & len_mask) == '0);

  always_comb begin
    pat_next  = pat_r;
    len_next  = len_r;
    ovl_next  = ovl_r;
    hist_next = hist;
    fill_next = fill;
    dout_next = 1'b0;
    cnt_next  = match_cnt;

    if (cfg_load) begin
      pat_next  = pat;
      len_next  = (pat_len > PAT_W_L) ? PAT_W_L : pat_len;
      ovl_next  = overlap;
      hist_next = '0;
      fill_next = '0;
    end else if (din_valid) begin
      hist_next = hist_shift;
      // Non-overlapping mode restarts the window so the next match needs fresh bits.
      fill_next = (hit && !ovl_r) ? '0 : fill_inc;
      dout_next = hit;
    end

    if (cnt_clr) begin
      cnt_next = '0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      cnt_next = match_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pat_r     <= DEF_PAT;
      len_r     <= DEF_LEN;
      ovl_r     <= DEF_OVL;
      hist      <= '0;
      fill      <= '0;
      dout      <= 1'b0;
      match_cnt <= '0;
    end else begin
      pat_r     <= pat_next;
      len_r     <= len_next;
      ovl_r     <= ovl_next;
      hist      <= hist_next;
      fill      <= fill_next;
      dout      <= dout_next;
      match_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus randomized traffic against a
// queue-based reference model; a second instance with a 2-bit counter checks saturation.
module tb_seq_det_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0, din_valid = 1'b0, cfg_load = 1'b0, overlap = 1'b0, cnt_clr = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] pat_len = '0;
  logic       dout, dout2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] fill, fill2;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: queue holds the valid bits of the current match window, oldest first.
  bit       q[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_dout;
  int       m_cnt, m_cnt2;

  seq_det_param u_dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .dout(dout), .match_cnt(match_cnt), .fill(fill)
  );

  seq_det_param #(.CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .dout(dout2), .match_cnt(match_cnt2), .fill(fill2)
  );

  always #5 clock = ~clock;

  function void model_reset();
    m_pat  = 8'b0000_0101;
    m_len  = 3;
    m_ovl  = 1'b1;
    q.delete();
    m_dout = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endfunction

  function void model_edge(bit d, bit v, bit ld, bit cc, bit [7:0] p, bit [3:0] pl, bit ov);
    bit hit;
    hit    = 1'b0;
    m_dout = 1'b0;
    if (ld) begin
      m_pat = p;
      m_len = (pl > 4'd8) ? 8 : int'(pl);
      m_ovl = ov;
      q.delete();
    end else if (v) begin
      q.push_back(d);
      while (q.size() > m_len) void'(q.pop_front());
      if (m_len > 0 && q.size() == m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (q[k] != m_pat[m_len-1-k]) hit = 1'b0;
      end
      if (hit) begin
        m_dout = 1'b1;
        if (!m_ovl) q.delete();
      end
    end
    if (cc) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (hit) begin
      m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
      m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
    end
  endfunction

  task automatic cyc(bit d, bit v, bit ld, bit cc, bit [7:0] p, bit [3:0] pl, bit ov);
    @(negedge clock);
    din = d; din_valid = v; cfg_load = ld; cnt_clr = cc; pat = p; pat_len = pl; overlap = ov;
    model_edge(d, v, ld, cc, p, pl, ov);
    @(posedge clock);
    #1;
    $display("txn t=%0t din=%0b v=%0b ld=%0b clr=%0b -> dout=%0b fill=%0d cnt=%0d cnt2=%0d",
             $time, d, v, ld, cc, dout, fill, match_cnt, match_cnt2);
    din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic bitv(bit d);
    cyc(d, 1'b1, 1'b0, 1'b0, pat, pat_len, overlap);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout got %0b want 0", dout); end
    n_chk++; if (fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", fill); end
    n_chk++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_default_overlap();
    bit seq[7]  = '{0, 1, 0, 1, 0, 1, 1};
    bit expd[7] = '{0, 0, 0, 1, 0, 1, 0};
    int expf[7] = '{1, 2, 3, 3, 3, 3, 3};
    for (int i = 0; i < 7; i++) begin
      bitv(seq[i]);
      n_chk++; if (dout !== expd[i]) begin n_fail++; $display("FAIL default_dout bit%0d got %0b want %0b", i + 1, dout, expd[i]); end
      n_chk++; if (fill !== 4'(expf[i])) begin n_fail++; $display("FAIL default_fill bit%0d got %0d want %0d", i + 1, fill, expf[i]); end
    end
    n_chk++; if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL default_cnt got %0d want 2", match_cnt); end
    n_chk++; if (match_cnt2 !== 2'd2) begin n_fail++; $display("FAIL default_cnt2 got %0d want 2", match_cnt2); end
  endtask

  task automatic test_nonoverlap();
    bit seq[5]  = '{1, 0, 1, 0, 1};
    bit expd[5] = '{0, 0, 1, 0, 0};
    int expf[5] = '{1, 2, 0, 1, 2};
    // Load and counter clear on the same edge.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b0);
    n_chk++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL nonovl_load_cnt got %0d want 0", match_cnt); end
    n_chk++; if (fill !== 4'd0) begin n_fail++; $display("FAIL nonovl_load_fill got %0d want 0", fill); end
    for (int i = 0; i < 5; i++) begin
      bitv(seq[i]);
      n_chk++; if (dout !== expd[i]) begin n_fail++; $display("FAIL nonovl_dout bit%0d got %0b want %0b", i + 1, dout, expd[i]); end
      n_chk++; if (fill !== 4'(expf[i])) begin n_fail++; $display("FAIL nonovl_fill bit%0d got %0d want %0d", i + 1, fill, expf[i]); end
    end
    n_chk++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL nonovl_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_gap();
    bit seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 2; g++) begin
          cyc(1'b1, 1'b0, 1'b0, 1'b0, pat, pat_len, overlap);
          n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL gap_dout idle%0d got %0b want 0", g, dout); end
          n_chk++; if (fill !== 4'd4) begin n_fail++; $display("FAIL gap_fill idle%0d got %0d want 4", g, fill); end
        end
      end
      bitv(seq[i]);
      n_chk++; if (dout !== (i == 7)) begin n_fail++; $display("FAIL gap_dout bit%0d got %0b want %0b", i + 1, dout, i == 7); end
    end
    n_chk++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL gap_cnt got %0d want 1", match_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    bitv(1'b1); bitv(1'b0); bitv(1'b1); bitv(1'b0);
    n_chk++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_pre_cnt got %0d want 1", match_cnt); end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (fill !== 4'd0) begin n_fail++; $display("FAIL rstmid_async_fill got %0d want 0", fill); end
    n_chk++; if (match_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_async_cnt got %0d want 0", match_cnt); end
    // Deassert and present the first bit for the very next edge.
    @(negedge clock);
    reset = 1'b0; din = 1'b1; din_valid = 1'b1;
    model_reset();
    model_edge(1'b1, 1'b1, 1'b0, 1'b0, pat, pat_len, overlap);
    @(posedge clock);
    #1;
    din_valid = 1'b0;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL rstmid_dout got %0b want 0", dout); end
    n_chk++; if (fill !== 4'd1) begin n_fail++; $display("FAIL rstmid_fill got %0d want 1", fill); end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'b11, 4'd2, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b1, 1'b0, (i == 8), pat, pat_len, overlap);
      if (i < 8) pulses += int'(dout);
      n_chk++; if (dout !== (i >= 1)) begin n_fail++; $display("FAIL sat_dout bit%0d got %0b want %0b", i + 1, dout, i >= 1); end
      n_chk++; if (match_cnt2 !== 2'((i == 8) ? 0 : ((i < 3) ? i : 3)))
        begin n_fail++; $display("FAIL sat_cnt2 bit%0d got %0d want %0d", i + 1, match_cnt2, (i == 8) ? 0 : ((i < 3) ? i : 3)); end
      n_chk++; if (match_cnt !== 8'((i == 8) ? 0 : i))
        begin n_fail++; $display("FAIL sat_cnt bit%0d got %0d want %0d", i + 1, match_cnt, (i == 8) ? 0 : i); end
    end
    n_chk++; if (pulses != 7) begin n_fail++; $display("FAIL sat_pulses got %0d want 7", pulses); end
  endtask

  task automatic test_cfg_same_edge();
    bit seq[3]  = '{1, 0, 1};
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'b101, 4'd3, 1'b1);
    bitv(1'b1); bitv(1'b0); bitv(1'b1); bitv(1'b0);
    // The completing '1' arrives together with a reload and must be discarded.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'b101, 4'd3, 1'b1);
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL cfgedge_dout got %0b want 0", dout); end
    n_chk++; if (fill !== 4'd0) begin n_fail++; $display("FAIL cfgedge_fill got %0d want 0", fill); end
    n_chk++; if (match_cnt !== 8'd1) begin n_fail++; $display("FAIL cfgedge_cnt got %0d want 1", match_cnt); end
    for (int i = 0; i < 3; i++) begin
      bitv(seq[i]);
      n_chk++; if (dout !== (i == 2)) begin n_fail++; $display("FAIL cfgedge_after_dout bit%0d got %0b want %0b", i + 1, dout, i == 2); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 31) == 0), 8'($urandom), 4'($urandom), 1'($urandom));
      n_chk++; if (dout !== m_dout) begin n_fail++; $display("FAIL rand_dout i%0d got %0b want %0b", i, dout, m_dout); end
      n_chk++; if (fill !== 4'(q.size())) begin n_fail++; $display("FAIL rand_fill i%0d got %0d want %0d", i, fill, q.size()); end
      n_chk++; if (match_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt i%0d got %0d want %0d", i, match_cnt, m_cnt); end
      n_chk++; if (match_cnt2 !== 2'(m_cnt2)) begin n_fail++; $display("FAIL rand_cnt2 i%0d got %0d want %0d", i, match_cnt2, m_cnt2); end
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_gap();
    test_reset_mid();
    test_saturate();
    test_cfg_same_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
